l2_stream_pointer: RTL and testbench

- Per-stream pointer/credit controller for an L2 stream buffer of l2_ncl cache lines held in URAM.
- After a functional stream reset it prefetches lines over the OpenCAPI 3.0 request/response interface until the buffer is full.
- It serves L1 read requests by issuing URAM read addresses, and refills each consumed slot with a new request.
- It sits between the L1 stream logic, the L2 URAM read port and the OpenCAPI command path.

---
 rtl/l2_stream_pointer.sv | 119 +++++++++++
 tb/tb_l2_stream_pointer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_stream_pointer.sv
// L2 stream buffer pointer/credit controller: prefetches cache lines after a functional
// reset, serves L1 reads from URAM and refills every consumed slot.
//
// state  | meaning
// IDLE   | after hardware reset; no requests, reads blocked, responses refused
// DRAIN  | swallow outstanding responses, then clear read pointer and line count
// ACK    | report functional reset completion until accepted
// ACTIVE | prefetch/refill lines and serve reads
`timescale 1ns/1ps

module l2_stream_pointer #(
   parameter int l2_ncl       = 256,
   parameter int l2_ncl_width = $clog2(l2_ncl)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_rst_v,
   output logic                    i_rst_r,
   output logic                    o_rst_v,
   input  logic                    o_rst_r,
   input  logic                    i_rd_v,
   output logic                    i_rd_r,
   output logic                    o_addr_v,
   input  logic                    o_addr_r,
   output logic [l2_ncl_width-1:0] o_addr_ptr,
   output logic                    o_req_v,
   input  logic                    o_req_r,
   input  logic                    i_rsp_v,
   output logic                    i_rsp_r
);

   localparam int CW = l2_ncl_width + 1;
   localparam logic [CW-1:0] NCL = CW'(l2_ncl);

   typedef enum logic [1:0] {IDLE, DRAIN, ACK, ACTIVE} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [l2_ncl_width-1:0] r_rd_ptr;
   logic [CW-1:0]           r_valid_cnt;
   logic [CW-1:0]           r_infl_cnt;

   logic [CW-1:0]           w_free;
   logic                    w_valid_nz;
   logic                    w_infl_nz;
   logic                    w_req_fire;
   logic                    w_rsp_fire;
   logic                    w_rd_fire;
   logic                    w_rsp_to_buf;
   logic                    w_drain_done;

   assign w_free     = NCL - r_valid_cnt - r_infl_cnt;
   assign w_valid_nz = (r_valid_cnt != '0);
   assign w_infl_nz  = (r_infl_cnt != '0);
   assign o_addr_ptr = r_rd_ptr;

   always_comb begin
      w_state_nxt = r_state;
      i_rst_r     = 1'b0;
      o_rst_v     = 1'b0;
      o_req_v     = 1'b0;
      i_rsp_r     = 1'b0;
      o_addr_v    = 1'b0;
      i_rd_r      = 1'b0;
      case (r_state)
         IDLE: begin
            i_rst_r = 1'b1;
            if (i_rst_v) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            i_rsp_r = 1'b1;
            if (!w_infl_nz) w_state_nxt = ACK;
         end
         ACK: begin
            o_rst_v = 1'b1;
            if (o_rst_r) w_state_nxt = ACTIVE;
         end
         ACTIVE: begin
            i_rst_r = 1'b1;
            i_rsp_r = w_infl_nz;
            // a pending stream reset freezes new requests and reads in its own cycle
            if (i_rst_v) begin
               w_state_nxt = DRAIN;
            end else begin
               o_req_v  = (w_free != '0);
               o_addr_v = i_rd_v & w_valid_nz;
               i_rd_r   = o_addr_r & w_valid_nz;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_req_fire   = o_req_v & o_req_r;
   assign w_rsp_fire   = i_rsp_v & i_rsp_r & w_infl_nz;
   assign w_rd_fire    = i_rd_v & i_rd_r;
   assign w_rsp_to_buf = w_rsp_fire & (r_state == ACTIVE);
   assign w_drain_done = (r_state == DRAIN) & ~w_infl_nz;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_rd_ptr    <= '0;
         r_valid_cnt <= '0;
         r_infl_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_infl_cnt <= r_infl_cnt + CW'(w_req_fire) - CW'(w_rsp_fire);
         if (w_drain_done) begin
            r_rd_ptr    <= '0;
            r_valid_cnt <= '0;
         end else begin
            if (w_rd_fire) r_rd_ptr <= r_rd_ptr + l2_ncl_width'(1);
            r_valid_cnt <= r_valid_cnt + CW'(w_rsp_to_buf) - CW'(w_rd_fire);
         end
      end
   end

endmodule

// File: tb/tb_l2_stream_pointer.sv
// Bench for l2_stream_pointer: directed scenarios plus randomized traffic checked against
// a slot-queue model of the stream buffer.
`timescale 1ns/1ps

module tb_l2_stream_pointer;

   localparam int NCL = 256;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       i_rst_v  = 1'b0;
   logic       o_rst_r  = 1'b0;
   logic       i_rd_v   = 1'b0;
   logic       o_addr_r = 1'b0;
   logic       o_req_r  = 1'b0;
   logic       i_rsp_v  = 1'b0;
   logic       i_rst_r, o_rst_v, i_rd_r, o_addr_v, o_req_v, i_rsp_r;
   logic [7:0] o_addr_ptr;

   int n_tests = 0;
   int n_fail  = 0;
   int pend    = 0;
   bit rsp_en  = 1'b0;

   l2_stream_pointer #(.l2_ncl(NCL)) dut (
      .clk(clk), .reset(reset),
      .i_rst_v(i_rst_v), .i_rst_r(i_rst_r),
      .o_rst_v(o_rst_v), .o_rst_r(o_rst_r),
      .i_rd_v(i_rd_v), .i_rd_r(i_rd_r),
      .o_addr_v(o_addr_v), .o_addr_r(o_addr_r), .o_addr_ptr(o_addr_ptr),
      .o_req_v(o_req_v), .o_req_r(o_req_r),
      .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r)
   );

   always #5 clk = ~clk;

   // OpenCAPI stand-in: in-order responder, one response per cycle when enabled
   always @(posedge clk or negedge reset) begin
      if (!reset) pend = 0;
      else pend = pend + ((o_req_v && o_req_r) ? 1 : 0) - ((i_rsp_v && i_rsp_r) ? 1 : 0);
   end

   // Reference model: buffer slots as queues of slot numbers
   int m_ph = 0;          // 0 idle, 1 draining, 2 acknowledging, 3 streaming
   int q_infl[$];
   int q_valid[$];
   int m_next = 0;

   function automatic int m_free();
      return NCL - q_valid.size() - q_infl.size();
   endfunction
   function automatic bit e_rst_r();
      return (m_ph == 0) || (m_ph == 3);
   endfunction
   function automatic bit e_rst_v();
      return m_ph == 2;
   endfunction
   function automatic bit e_req_v();
      return (m_ph == 3) && !i_rst_v && (m_free() > 0);
   endfunction
   function automatic bit e_rsp_r();
      return (m_ph == 1) || ((m_ph == 3) && (q_infl.size() > 0));
   endfunction
   function automatic bit e_rd_r();
      return (m_ph == 3) && !i_rst_v && o_addr_r && (q_valid.size() > 0);
   endfunction
   function automatic bit e_addr_v();
      return (m_ph == 3) && !i_rst_v && i_rd_v && (q_valid.size() > 0);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ph = 0; q_infl.delete(); q_valid.delete(); m_next = 0;
      end else begin
         bit rq, rs, rd, rst, ack, dd;
         int s;
         rq  = e_req_v() && o_req_r;
         rs  = i_rsp_v && e_rsp_r();
         rd  = i_rd_v && e_rd_r();
         rst = i_rst_v && e_rst_r();
         ack = (m_ph == 2) && o_rst_r;
         dd  = (m_ph == 1) && (q_infl.size() == 0);
         if (rs && q_infl.size() > 0) begin
            s = q_infl.pop_front();
            if (m_ph == 3) q_valid.push_back(s);
         end
         if (rd) void'(q_valid.pop_front());
         if (rq) begin
            q_infl.push_back(m_next);
            m_next = (m_next + 1) % NCL;
         end
         if ((m_ph == 0 || m_ph == 3) && rst) m_ph = 1;
         else if (dd) begin
            m_ph = 2; q_valid.delete(); m_next = 0;
         end else if (ack) m_ph = 3;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      i_rsp_v = rsp_en && (pend > 0);
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b0; i_rd_v = 1'b1; o_addr_r = 1'b1; o_req_r = 1'b1; o_rst_r = 1'b1;
      #50;
      n_tests++;
      if ({o_rst_v, o_req_v, i_rd_r, o_addr_v, i_rsp_r} !== 5'b0) begin
         n_fail++; $display("FAIL reset_outputs: got %b want 00000", {o_rst_v, o_req_v, i_rd_r, o_addr_v, i_rsp_r});
      end
      n_tests++;
      if (i_rst_r !== 1'b1) begin n_fail++; $display("FAIL reset_rst_r: got %b want 1", i_rst_r); end
      n_tests++;
      if (o_addr_ptr !== 8'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", o_addr_ptr); end
      #50;
      i_rd_v = 1'b0; o_addr_r = 1'b0; o_req_r = 1'b0; o_rst_r = 1'b0;
      @(posedge clk); #1; reset = 1'b1;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (o_req_v !== 1'b0 || i_rst_r !== 1'b1) bad++;
         tick();
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_fill();
      int acks, bad;
      o_rst_r = 1'b1; o_req_r = 1'b1; rsp_en = 1'b1; i_rst_v = 1'b1;
      @(negedge clk);
      n_tests++;
      if (i_rst_r !== 1'b1) begin n_fail++; $display("FAIL fill_rst_accept: got %b want 1", i_rst_r); end
      tick(); i_rst_v = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({i_rst_r, o_req_v, i_rsp_r, o_rst_v} !== 4'b0010) begin
         n_fail++; $display("FAIL fill_drain_outs: got %b want 0010", {i_rst_r, o_req_v, i_rsp_r, o_rst_v});
      end
      tick();
      acks = 0;
      @(negedge clk);
      while (o_rst_v === 1'b1 && acks < 10) begin acks++; tick(); @(negedge clk); end
      n_tests++;
      if (acks != 1) begin n_fail++; $display("FAIL fill_ack_len: got %0d want 1", acks); end
      bad = 0;
      for (int k = 0; k < NCL; k++) begin
         if (o_req_v !== 1'b1) bad++;
         tick(); @(negedge clk);
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL fill_consecutive: got %0d gaps want 0", bad); end
      n_tests++;
      if ({o_req_v, i_rsp_r} !== 2'b01) begin n_fail++; $display("FAIL fill_stop: got %b want 01", {o_req_v, i_rsp_r}); end
      tick(); @(negedge clk);
      n_tests++;
      if ({o_req_v, i_rsp_r} !== 2'b00) begin n_fail++; $display("FAIL fill_full: got %b want 00", {o_req_v, i_rsp_r}); end
      tick();
   endtask

   task automatic test_read_refill();
      i_rd_v = 1'b1; o_addr_r = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({o_addr_v, i_rd_r, o_req_v, o_addr_ptr} !== {3'b110, 8'd0}) begin
         n_fail++; $display("FAIL rr_first: got %b/%0d want 110/0", {o_addr_v, i_rd_r, o_req_v}, o_addr_ptr);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if ({o_addr_v, i_rd_r, o_req_v, o_addr_ptr} !== {3'b111, 8'd1}) begin
         n_fail++; $display("FAIL rr_second: got %b/%0d want 111/1", {o_addr_v, i_rd_r, o_req_v}, o_addr_ptr);
      end
      tick(); i_rd_v = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({o_addr_v, o_req_v} !== 2'b01) begin n_fail++; $display("FAIL rr_refill2: got %b want 01", {o_addr_v, o_req_v}); end
      tick();
      @(negedge clk);
      n_tests++;
      if (o_req_v !== 1'b0) begin n_fail++; $display("FAIL rr_no_extra: got %b want 0", o_req_v); end
      tick();
      @(negedge clk);
      n_tests++;
      if ({o_req_v, i_rsp_r} !== 2'b00) begin n_fail++; $display("FAIL rr_full_again: got %b want 00", {o_req_v, i_rsp_r}); end
      tick();
   endtask

   task automatic test_wrap();
      int sb_valid, sb_infl, n, exp_ptr, prev, badptr, viol, rq, rs, rd;
      bit wrapped;
      sb_valid = NCL; sb_infl = 0; n = 0; exp_ptr = 2; prev = -1; badptr = 0; viol = 0; wrapped = 1'b0;
      i_rd_v = 1'b1; o_addr_r = 1'b1; o_req_r = 1'b1;
      for (int k = 0; k < 2000 && n < 257; k++) begin
         @(negedge clk);
         rq = (o_req_v && o_req_r) ? 1 : 0;
         rs = (i_rsp_v && i_rsp_r) ? 1 : 0;
         rd = (i_rd_v && i_rd_r) ? 1 : 0;
         if (o_req_v && (NCL - sb_valid - sb_infl) == 0) viol++;
         if (rd == 1) begin
            if (o_addr_ptr !== 8'(exp_ptr)) badptr++;
            if (prev == 255 && o_addr_ptr == 8'd0) wrapped = 1'b1;
            prev = int'(o_addr_ptr);
            exp_ptr = (exp_ptr + 1) % NCL;
            n++;
         end
         sb_valid = sb_valid + rs - rd;
         sb_infl  = sb_infl + rq - rs;
         tick();
      end
      i_rd_v = 1'b0;
      n_tests++;
      if (n != 257) begin n_fail++; $display("FAIL wrap_reads: got %0d want 257", n); end
      n_tests++;
      if (badptr != 0) begin n_fail++; $display("FAIL wrap_ptr_order: got %0d wrong want 0", badptr); end
      n_tests++;
      if (!wrapped) begin n_fail++; $display("FAIL wrap_255_to_0: got 0 want 1"); end
      n_tests++;
      if (viol != 0) begin n_fail++; $display("FAIL wrap_req_when_full: got %0d want 0", viol); end
      repeat (6) tick();
      @(negedge clk);
      n_tests++;
      if ({o_req_v, i_rsp_r} !== 2'b00) begin n_fail++; $display("FAIL wrap_settle: got %b want 00", {o_req_v, i_rsp_r}); end
      tick();
   endtask

   task automatic test_drain();
      int bad, drained, cyc, hold, reqs;
      rsp_en = 1'b0; i_rd_v = 1'b1; o_addr_r = 1'b1; bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (i_rd_r !== 1'b1) bad++;
         tick();
      end
      i_rd_v = 1'b0;
      repeat (6) tick();
      @(negedge clk);
      n_tests++;
      if (bad != 0 || pend != 3 || {o_req_v, i_rsp_r} !== 2'b01) begin
         n_fail++; $display("FAIL drain_setup: got bad=%0d pend=%0d vr=%b want 0/3/01", bad, pend, {o_req_v, i_rsp_r});
      end
      tick();
      i_rst_v = 1'b1; o_rst_r = 1'b0; rsp_en = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({i_rst_r, o_req_v} !== 2'b10) begin n_fail++; $display("FAIL drain_accept: got %b want 10", {i_rst_r, o_req_v}); end
      tick(); i_rst_v = 1'b0;
      drained = 0; cyc = 0;
      @(negedge clk);
      while (o_rst_v !== 1'b1 && cyc < 20) begin
         if (i_rsp_v && i_rsp_r) drained++;
         cyc++; tick(); @(negedge clk);
      end
      n_tests++;
      if (drained != 3 || o_rst_v !== 1'b1) begin
         n_fail++; $display("FAIL drain_rsp: got %0d rsp ack=%b want 3 ack=1", drained, o_rst_v);
      end
      hold = 0;
      for (int k = 0; k < 5; k++) begin
         if (o_rst_v === 1'b1) hold++;
         tick(); @(negedge clk);
      end
      n_tests++;
      if (hold != 5 || o_rst_v !== 1'b1) begin n_fail++; $display("FAIL drain_ack_hold: got %0d/%b want 5/1", hold, o_rst_v); end
      o_rst_r = 1'b1;
      tick();
      i_rd_v = 1'b1; o_addr_r = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({o_rst_v, o_req_v, i_rd_r, o_addr_v} !== 4'b0100) begin
         n_fail++; $display("FAIL drain_empty_read: got %b want 0100", {o_rst_v, o_req_v, i_rd_r, o_addr_v});
      end
      reqs = (o_req_v && o_req_r) ? 1 : 0;
      tick(); i_rd_v = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (o_req_v && o_req_r) reqs++;
         tick();
      end
      n_tests++;
      if (reqs != NCL) begin n_fail++; $display("FAIL drain_refill: got %0d reqs want %0d", reqs, NCL); end
   endtask

   task automatic test_blocked();
      i_rd_v = 1'b1; o_addr_r = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({i_rd_r, o_addr_v, o_addr_ptr} !== {2'b01, 8'd0}) begin
         n_fail++; $display("FAIL blocked_no_ready: got %b/%0d want 01/0", {i_rd_r, o_addr_v}, o_addr_ptr);
      end
      tick(); o_addr_r = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({i_rd_r, o_addr_ptr} !== {1'b1, 8'd0}) begin
         n_fail++; $display("FAIL blocked_ptr_held: got %b/%0d want 1/0", i_rd_r, o_addr_ptr);
      end
      tick(); i_rd_v = 1'b0;
      @(negedge clk);
      n_tests++;
      if (o_addr_ptr !== 8'd1) begin n_fail++; $display("FAIL blocked_ptr_adv: got %0d want 1", o_addr_ptr); end
      tick();
   endtask

   task automatic test_random();
      logic [5:0] e, g;
      for (int k = 0; k < 3000; k++) begin
         i_rd_v   = 1'($urandom_range(0, 1));
         o_addr_r = ($urandom_range(0, 3) != 0);
         o_req_r  = ($urandom_range(0, 3) != 0);
         rsp_en   = ($urandom_range(0, 3) != 0);
         o_rst_r  = 1'($urandom_range(0, 1));
         i_rst_v  = ($urandom_range(0, 299) == 0);
         @(negedge clk);
         e = {e_rst_r(), e_rst_v(), e_req_v(), e_rsp_r(), e_rd_r(), e_addr_v()};
         g = {i_rst_r, o_rst_v, o_req_v, i_rsp_r, i_rd_r, o_addr_v};
         n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL rand_handshake cyc %0d: got %b want %b", k, g, e); end
         if (e[0]) begin
            n_tests++;
            if (o_addr_ptr !== 8'(q_valid[0])) begin
               n_fail++; $display("FAIL rand_ptr cyc %0d: got %0d want %0d", k, o_addr_ptr, q_valid[0]);
            end
         end
         tick();
      end
      i_rst_v = 1'b0; i_rd_v = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_read_refill();
      test_wrap();
      test_drain();
      test_blocked();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
